// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order instruction fetch with response FIFO and redirect flush
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            ins_valid,
    output logic [XLEN-1:0] ins_out,
    output logic [XLEN-1:0] pc_out,
    output logic [8:0]      ctrl_idx
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   ONE     = 1;
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
    localparam logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] STEP  = XLEN'(4);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] fifo_ins [DEPTH];
    logic [XLEN-1:0] fifo_pc  [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [AW:0]     outstanding, kill, out_next;
    logic [AW:0]     occupancy;
    logic            accept, resp, wr_en, pop;
    logic [XLEN-1:0] target_pc;

    assign occupancy = wr_ptr - rd_ptr;
    assign imem_req  = !rst && (({1'b0, occupancy} + {1'b0, outstanding}) < DEPTH_W);
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp      = imem_rvalid && (outstanding != '0);
    assign wr_en     = resp && (kill == '0) && !redirect;
    assign ins_valid = (wr_ptr != rd_ptr);
    assign pop       = ins_valid && !stall && !redirect;
    assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        out_next = outstanding;
        if (accept && !resp)
            out_next = outstanding + ONE;
        else if (!accept && resp)
            out_next = outstanding - ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            kill        <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect) begin
                // Everything in flight after this edge belongs to the old stream.
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                rd_ptr   <= wr_ptr;
                kill     <= out_next;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + STEP;
                if (resp) begin
                    if (kill != '0) begin
                        kill <= kill - ONE;
                    end else begin
                        wr_ptr  <= wr_ptr + ONE;
                        resp_pc <= resp_pc + STEP;
                    end
                end
                if (pop)
                    rd_ptr <= rd_ptr + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            fifo_ins[wr_ptr[AW-1:0]] <= imem_rdata;
            fifo_pc[wr_ptr[AW-1:0]]  <= resp_pc;
        end
    end

    always_comb begin
        ins_out  = NOP;
        pc_out   = '0;
        ctrl_idx = 9'b0_000_11111;
        if (ins_valid) begin
            ins_out  = fifo_ins[rd_ptr[AW-1:0]];
            pc_out   = fifo_pc[rd_ptr[AW-1:0]];
            ctrl_idx = {ins_out[30], ins_out[14:12], ins_out[6:2]};
        end
    end
endmodule
